// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter granting two byte requesters access to one UART transmitter.
// Launch timeout and inter-frame gap are enforced with a shared saturating down-counter.
module uart_tx_arbiter #(
   parameter int unsigned GAP_CYCLES     = 868,
   parameter int unsigned LAUNCH_TIMEOUT = 1736
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic [7:0] data0,
   input  logic [7:0] data1,
   output logic       ack0,
   output logic       ack1,
   output logic       done0,
   output logic       done1,
   output logic       timeout,
   output logic [7:0] tx_data,
   output logic       tx_enable,
   input  logic       tx_busy,
   output logic       owner,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;
   localparam logic [15:0] GAP_LD = 16'(GAP_CYCLES);
   localparam logic [15:0] LT_LD  = 16'(LAUNCH_TIMEOUT);
   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        owner_q, owner_d, last_q, last_d;
   logic        ack0_q, ack0_d, ack1_q, ack1_d;
   logic        done0_q, done0_d, done1_q, done1_d;
   logic        timeout_q, timeout_d, tx_enable_q, tx_enable_d;
   logic        win;
   always_comb begin
      win         = (req0 && req1) ? ~last_q : req1;
      state_d     = state_q;
      cnt_d       = cnt_q;
      tx_data_d   = tx_data_q;
      owner_d     = owner_q;
      last_d      = last_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      done0_d     = 1'b0;
      done1_d     = 1'b0;
      timeout_d   = 1'b0;
      tx_enable_d = tx_enable_q;
      case (state_q)
         IDLE: if (req0 || req1) begin
            state_d     = LAUNCH;
            tx_data_d   = win ? data1 : data0;
            owner_d     = win;
            last_d      = win;
            ack0_d      = ~win;
            ack1_d      = win;
            tx_enable_d = 1'b1;
            cnt_d       = LT_LD;
         end
         LAUNCH: if (tx_busy) begin
            tx_enable_d = 1'b0;
            state_d     = WAIT_DONE;
         end else if (cnt_q <= 16'd1) begin
            tx_enable_d = 1'b0;
            timeout_d   = 1'b1;
            cnt_d       = GAP_LD;
            state_d     = GAP;
         end else begin
            cnt_d = cnt_q - 16'd1;
         end
         WAIT_DONE: if (!tx_busy) begin
            done0_d = ~owner_q;
            done1_d = owner_q;
            cnt_d   = GAP_LD;
            state_d = GAP;
         end
         GAP: if (cnt_q == 16'd0) state_d = IDLE;
              else cnt_d = cnt_q - 16'd1;
         default: state_d = IDLE;
      endcase
   end
   // last grant resets to requester 1 so requester 0 wins the first contention
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= 16'd0;
         tx_data_q   <= 8'h00;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         timeout_q   <= 1'b0;
         tx_enable_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tx_data_q   <= tx_data_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         done0_q     <= done0_d;
         done1_q     <= done1_d;
         timeout_q   <= timeout_d;
         tx_enable_q <= tx_enable_d;
      end
   end
   assign ack0      = ack0_q;
   assign ack1      = ack1_q;
   assign done0     = done0_q;
   assign done1     = done1_q;
   assign timeout   = timeout_q;
   assign tx_data   = tx_data_q;
   assign tx_enable = tx_enable_q;
   assign owner     = owner_q;
   assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a behavioural transmitter model and a frame-level
// reference of the arbitration rules, gap length and launch timeout.
module tb_uart_tx_arbiter;
   localparam int GAP = 4;
   localparam int LT  = 16;
   logic       clk = 0, reset = 1;
   logic [1:0] req = 2'b00;
   logic [7:0] data [2];
   logic [1:0] ack, done;
   logic       timeout, tx_enable, owner, busy;
   logic       tx_busy = 0;
   logic [7:0] tx_data;
   int checks = 0, errors = 0;
   int cycle = 0, ack_cycle = 0, end_cycle = 0;
   int tx_delay = 1, tx_len = 10;
   bit tx_never = 0;
   bit model_last = 1;
   logic [7:0] exp_q0[$], exp_q1[$];
   int out_q[$];
   int grant_log[$];

   uart_tx_arbiter #(.GAP_CYCLES(GAP), .LAUNCH_TIMEOUT(LT)) dut (
      .clk(clk), .reset(reset), .req0(req[0]), .req1(req[1]),
      .data0(data[0]), .data1(data[1]), .ack0(ack[0]), .ack1(ack[1]),
      .done0(done[0]), .done1(done[1]), .timeout(timeout), .tx_data(tx_data),
      .tx_enable(tx_enable), .tx_busy(tx_busy), .owner(owner), .busy(busy));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
      end
   endtask

   // requester: raise req with a byte, hold until acked, then drop
   task automatic issue(input int i, input logic [7:0] d);
      data[i] = d;
      req[i]  = 1'b1;
      if (i == 0) exp_q0.push_back(d); else exp_q1.push_back(d);
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if (ack[i]) begin
            req[i] = 1'b0;
            return;
         end
      end
      req[i] = 1'b0;
      checks++;
      errors++;
      $display("FAIL ack_wait%0d: no ack within 3000 cycles", i);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 5000; n++) begin
         @(negedge clk);
         if (!busy && !tx_busy && req == 2'b00) return;
      end
      checks++;
      errors++;
      $display("FAIL idle_wait: arbiter still busy=%0b after 5000 cycles", busy);
   endtask

   // transmitter model: busy rises tx_delay cycles after enable is seen, lasts tx_len cycles
   initial begin
      forever begin
         @(negedge clk);
         if (tx_enable && !tx_busy && !tx_never && !reset) begin
            repeat (tx_delay) @(negedge clk);
            tx_busy = 1'b1;
            repeat (tx_len) @(negedge clk);
            tx_busy = 1'b0;
         end
      end
   end

   // monitor / scoreboard
   initial begin
      logic       pbusy, pen;
      logic [7:0] pdata;
      int         i, e, a;
      pbusy = 0; pen = 0; pdata = 0;
      forever begin
         @(posedge clk);
         #1;
         cycle++;
         if (reset) begin
            pbusy = 0; pen = 0; pdata = 0; model_last = 1;
         end else begin
            if (|ack) begin
               chk("ack_onehot", $countones(ack), 1);
               i = ack[1] ? 1 : 0;
               chk("ack_only_from_idle", pbusy, 0);
               chk("grant_owner", owner, i);
               chk("enable_on_grant", tx_enable, 1);
               if (req[1-i]) chk("round_robin", i, !model_last);
               model_last = i[0];
               grant_log.push_back(i);
               if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
                  checks++; errors++;
                  $display("FAIL unexpected_ack%0d at cycle %0d", i, cycle);
               end else begin
                  chk("tx_data", tx_data, i == 0 ? exp_q0.pop_front() : exp_q1.pop_front());
                  out_q.push_back(i + (tx_never ? 2 : 0));
               end
               ack_cycle = cycle;
            end else begin
               chk("tx_data_stable", tx_data, pdata);
            end
            if (pen && tx_busy) chk("enable_drop_after_busy", tx_enable, 0);
            if (|done || timeout) begin
               chk("completion_onehot", $countones({done, timeout}), 1);
               a = timeout ? 2 + int'(owner) : (done[1] ? 1 : 0);
               if (out_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_completion: got %0d expected none", a);
               end else begin
                  e = out_q.pop_front();
                  chk("completion_kind", a, e);
               end
               if (timeout) chk("timeout_latency", cycle - ack_cycle, LT);
               end_cycle = cycle;
            end
            if (pbusy && !busy) chk("gap_length", cycle - end_cycle, GAP + 1);
            pbusy = busy; pen = tx_enable; pdata = tx_data;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int  g, m;
      bit  saw;
      logic [7:0] d0, d1;
      data[0] = 0; data[1] = 0;
      #12;
      chk("reset_state", {tx_enable, ack, done, timeout, busy, owner, tx_data}, 0);
      @(negedge clk);
      reset = 0;
      @(negedge clk);
      // simultaneous requests right after reset: requester 0 first
      g = grant_log.size();
      fork
         issue(0, 8'h11);
         issue(1, 8'h22);
      join
      wait_idle();
      chk("contention_first", grant_log[g], 0);
      chk("contention_second", grant_log[g+1], 1);
      // both requesters held for four frames
      g = grant_log.size();
      fork
         begin issue(0, 8'h31); issue(0, 8'h32); end
         begin issue(1, 8'h41); issue(1, 8'h42); end
      join
      wait_idle();
      for (int k = 0; k < 4; k++) chk("alternate_order", grant_log[g+k], k % 2);
      // single long frame
      tx_delay = 1; tx_len = 96;
      issue(0, 8'hA5);
      wait_idle();
      // transmitter never starts
      tx_never = 1;
      issue(0, 8'h96);
      wait_idle();
      tx_never = 0;
      tx_len = 10;
      // req1 raised and dropped while the arbiter is in its gap
      issue(0, 8'h3C);
      for (int n = 0; n < 500 && !done[0]; n++) @(negedge clk);
      chk("done0_seen", done[0], 1);
      g = grant_log.size();
      data[1] = 8'h77; req[1] = 1;
      @(negedge clk);
      req[1] = 0;
      saw = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (n > GAP + 2 && (tx_enable || ack[1])) saw = 1;
      end
      chk("dropped_req_no_grant", saw, 0);
      chk("dropped_req_idle", busy, 0);
      chk("dropped_req_log", grant_log.size(), g);
      // reset in the middle of a frame
      tx_delay = 0; tx_len = 50;
      issue(0, 8'h5A);
      repeat (5) @(negedge clk);
      chk("in_wait_done", {busy, tx_busy, tx_enable}, 3'b110);
      #2 reset = 1;
      #1 chk("reset_async", {tx_enable, ack, done, timeout, busy, owner, tx_data}, 0);
      out_q.delete(); exp_q0.delete(); exp_q1.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      for (int n = 0; n < 200 && tx_busy; n++) @(negedge clk);
      tx_len = 10;
      g = grant_log.size();
      issue(1, 8'hC3);
      wait_idle();
      chk("grant_after_reset", grant_log.size(), g + 1);
      // randomized traffic
      for (int it = 0; it < 25; it++) begin
         tx_delay = $urandom_range(0, 3);
         tx_len   = $urandom_range(1, 20);
         tx_never = ($urandom_range(0, 5) == 0);
         m  = $urandom_range(1, 3);
         d0 = 8'($urandom);
         d1 = 8'($urandom);
         fork
            begin if (m[0]) issue(0, d0); end
            begin if (m[1]) issue(1, d1); end
         join
         wait_idle();
      end
      tx_never = 0;
      repeat (5) @(negedge clk);
      chk("outcomes_drained", out_q.size(), 0);
      chk("requests_drained", exp_q0.size() + exp_q1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
